// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
// Shared constants and types for the pooled feature-map path.
//   POOL_NCH   : channels interleaved in the pooling output stream
//   POOL_NCOL  : pooled columns per pooled row
//   POOL_DW    : default sample width
//   fm_state_t : frame buffer phase (FILL collects a frame, DRAIN streams it)
// -----------------------------------------------------------------------------
package lenet_pkg;

   localparam int POOL_NCH  = 3;
   localparam int POOL_NCOL = 3;
   localparam int POOL_DW   = 8;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } fm_state_t;

endpackage

// File: rtl/pool_fm_ram.sv
// -----------------------------------------------------------------------------
// pool_fm_ram
// Register-array frame store: one synchronous write port, one combinational
// read port. Contents reset to zero so the read port shows a defined value
// straight out of reset.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears every word
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module pool_fm_ram #(
   parameter int DEPTH = 27,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (int'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Address space is a power of two wider than DEPTH; unused codes read 0.
   assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/pool_fm_buffer.sv
// -----------------------------------------------------------------------------
// pool_fm_buffer
// Collects one pooled frame from the channel-interleaved pooling stream,
// stores it channel-major, then streams it out one channel plane at a time.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   cnn_out   : CNN core output strobe
//   pool_flag : pooling-complete level; sample accepted when cnn_out && pool_flag
//   pool_data : pooled sample
//   fm_valid  : output sample valid (high for the whole drain phase)
//   fm_ready  : downstream ready
//   fm_data   : output sample
//   fm_ch     : channel of the current output sample
//   fm_last   : final sample of the frame
//   overflow  : sticky, a sample arrived while draining and was dropped
// -----------------------------------------------------------------------------
module pool_fm_buffer
   import lenet_pkg::*;
#(
   parameter int POOL_ROWS = 3,
   parameter int DW        = POOL_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cnn_out,
   input  logic          pool_flag,
   input  logic [DW-1:0] pool_data,
   output logic          fm_valid,
   input  logic          fm_ready,
   output logic [DW-1:0] fm_data,
   output logic [1:0]    fm_ch,
   output logic          fm_last,
   output logic          overflow
);

   localparam int NPIX  = POOL_NCOL * POOL_ROWS;
   localparam int DEPTH = POOL_NCH * NPIX;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(POOL_NCH);
   localparam int LW    = $clog2(POOL_NCOL);
   localparam int RW    = (POOL_ROWS > 1) ? $clog2(POOL_ROWS) : 1;

   localparam logic [CW-1:0] CH_LAST   = CW'(POOL_NCH - 1);
   localparam logic [LW-1:0] COL_LAST  = LW'(POOL_NCOL - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(POOL_ROWS - 1);
   localparam logic [AW-1:0] RPTR_LAST = AW'(DEPTH - 1);

   fm_state_t     state_q;
   logic          fm_valid_q;
   logic [AW-1:0] rptr_q;

   logic [CW-1:0] wch_q,  wch_d;
   logic [LW-1:0] wcol_q, wcol_d;
   logic [RW-1:0] wrow_q, wrow_d;
   logic          overflow_q, overflow_d;

   logic          accept;
   logic          rd_fire;
   logic          final_hs;
   logic          wr_en;
   logic          frame_end;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] rd_data;

   // ---------------------------------------------------------------------------
   // Write qualification and write-counter next state
   // ---------------------------------------------------------------------------
   always_comb begin
      accept   = cnn_out && pool_flag;
      rd_fire  = fm_valid_q && fm_ready;
      final_hs = rd_fire && (rptr_q == RPTR_LAST);

      // During DRAIN the only write allowed is the one coinciding with the
      // last handshake: address 0 has been read by then, so it becomes the
      // first sample of the next frame instead of being dropped.
      wr_en     = accept && ((state_q == FILL) || final_hs);
      frame_end = accept && (state_q == FILL) &&
                  (wch_q == CH_LAST) && (wcol_q == COL_LAST) && (wrow_q == ROW_LAST);

      wch_d  = wch_q;
      wcol_d = wcol_q;
      wrow_d = wrow_q;
      if (frame_end) begin
         wch_d  = '0;
         wcol_d = '0;
         wrow_d = '0;
      end else if (wr_en) begin
         if (wch_q == CH_LAST) begin
            wch_d = '0;
            if (wcol_q == COL_LAST) begin
               wcol_d = '0;
               wrow_d = (wrow_q == ROW_LAST) ? '0 : (wrow_q + RW'(1));
            end else begin
               wcol_d = wcol_q + LW'(1);
            end
         end else begin
            wch_d = wch_q + CW'(1);
         end
      end

      overflow_d = overflow_q || (accept && (state_q == DRAIN) && !final_hs);

      // Channel-major placement: plane per channel, raster order inside a plane.
      wr_addr = AW'(int'(wch_q) * NPIX + int'(wrow_q) * POOL_NCOL + int'(wcol_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wch_q      <= '0;
         wcol_q     <= '0;
         wrow_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wch_q      <= wch_d;
         wcol_q     <= wcol_d;
         wrow_q     <= wrow_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Phase FSM with registered valid and read pointer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         fm_valid_q <= 1'b0;
         rptr_q     <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (frame_end) begin
                  state_q    <= DRAIN;
                  fm_valid_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (rd_fire) begin
                  if (rptr_q == RPTR_LAST) begin
                     rptr_q     <= '0;
                     state_q    <= FILL;
                     fm_valid_q <= 1'b0;
                  end else begin
                     rptr_q <= rptr_q + AW'(1);
                  end
               end
            end
            default: begin
               state_q    <= FILL;
               fm_valid_q <= 1'b0;
               rptr_q     <= '0;
            end
         endcase
      end
   end

   pool_fm_ram #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (pool_data),
      .raddr_i (rptr_q),
      .rdata_o (rd_data)
   );

   // Output fields derive from the held read pointer, so they stay stable
   // while the consumer stalls.
   assign fm_valid = fm_valid_q;
   assign fm_data  = rd_data;
   assign fm_ch    = 2'(int'(rptr_q) / NPIX);
   assign fm_last  = (rptr_q == RPTR_LAST);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_pool_fm_buffer.sv
module tb_pool_fm_buffer;

   localparam int NPIX  = 9;
   localparam int NSAMP = 27;

   logic       clk;
   logic       rst_n;
   logic       cnn_out;
   logic       pool_flag;
   logic [7:0] pool_data;
   logic       fm_valid;
   logic       fm_ready;
   logic [7:0] fm_data;
   logic [1:0] fm_ch;
   logic       fm_last;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   pool_fm_buffer #(
      .POOL_ROWS (3),
      .DW        (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnn_out   (cnn_out),
      .pool_flag (pool_flag),
      .pool_data (pool_data),
      .fm_valid  (fm_valid),
      .fm_ready  (fm_ready),
      .fm_data   (fm_data),
      .fm_ch     (fm_ch),
      .fm_last   (fm_last),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Drain position k holds sample (k%9)*3 + k/9 of the interleaved input.
   function automatic logic [7:0] exp_val(input int base, input int k);
      return 8'(base + (k % NPIX) * 3 + k / NPIX);
   endfunction

   // Send samples start..26 with value base+i, one accept per cycle.
   task automatic send_frame(input int base, input int start);
      for (int i = start; i < NSAMP; i++) begin
         @(negedge clk);
         if (i == NSAMP - 1) chk("valid_pre", {31'd0, fm_valid}, 32'd0);
         cnn_out   = 1'b1;
         pool_flag = 1'b1;
         pool_data = 8'(base + i);
      end
   endtask

   // Drain n samples; optional backpressure, optional accept injected at k==inj_k,
   // optional override of the first expected value.
   task automatic drain(input int base, input int n, input bit toggle, input int inj_k,
                        input logic [7:0] inj_val, input bit use_v0, input logic [7:0] v0);
      int  k = 0;
      int  cyc = 0;
      bit  injected = 1'b0;
      bit  prev_inj = 1'b0;
      logic [7:0] ev;
      while (k < n && cyc < 300) begin
         @(negedge clk);
         if (cyc == 0) chk("valid_rise", {31'd0, fm_valid}, 32'd1);
         if (prev_inj) begin
            chk("ovf_next", {31'd0, overflow}, 32'd1);
            prev_inj = 1'b0;
         end
         ev = (use_v0 && k == 0) ? v0 : exp_val(base, k);
         if (fm_valid) begin
            chk("fm_data", {24'd0, fm_data}, {24'd0, ev});
            chk("fm_ch",   {30'd0, fm_ch}, 32'(k / NPIX));
            chk("fm_last", {31'd0, fm_last}, {31'd0, (k == NSAMP - 1)});
         end
         fm_ready  = toggle ? cyc[0] : 1'b1;
         cnn_out   = 1'b0;
         pool_flag = 1'b0;
         if (k == inj_k && !injected) begin
            cnn_out   = 1'b1;
            pool_flag = 1'b1;
            pool_data = inj_val;
            injected  = 1'b1;
            prev_inj  = (k != NSAMP - 1);
         end
         if (fm_valid && fm_ready) k++;
         cyc++;
      end
      if (k < n) chk("drain_timeout", 32'(k), 32'(n));
      if (n == NSAMP) begin
         @(negedge clk);
         cnn_out   = 1'b0;
         pool_flag = 1'b0;
         chk("valid_fall", {31'd0, fm_valid}, 32'd0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cnn_out   = 1'b0;
      pool_flag = 1'b0;
      pool_data = 8'd0;
      fm_ready  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, fm_valid}, 32'd0);
      chk("rst_data",  {24'd0, fm_data}, 32'd0);
      chk("rst_ch",    {30'd0, fm_ch}, 32'd0);
      chk("rst_last",  {31'd0, fm_last}, 32'd0);
      chk("rst_ovf",   {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;

      // Qualification: half-asserted strobes must not write or advance counters.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cnn_out   = i[0];
         pool_flag = ~i[0];
         pool_data = 8'hEE;
         fm_ready  = 1'b1;
      end
      @(negedge clk);
      cnn_out   = 1'b0;
      pool_flag = 1'b0;
      chk("qual_valid", {31'd0, fm_valid}, 32'd0);
      chk("qual_data",  {24'd0, fm_data}, 32'd0);

      // Basic frame, ready held high.
      send_frame(0, 0);
      drain(0, NSAMP, 1'b0, -1, 8'h00, 1'b0, 8'h00);

      // Backpressure frame.
      send_frame(100, 0);
      drain(100, NSAMP, 1'b1, -1, 8'h00, 1'b0, 8'h00);
      chk("ovf_clean", {31'd0, overflow}, 32'd0);

      // Accept coinciding with the final handshake starts the next frame.
      send_frame(10, 0);
      drain(10, NSAMP, 1'b0, NSAMP - 1, 8'hAA, 1'b0, 8'h00);
      chk("simul_ovf", {31'd0, overflow}, 32'd0);
      send_frame(10, 1);
      drain(10, NSAMP, 1'b0, -1, 8'h00, 1'b1, 8'hAA);
      chk("simul_ovf2", {31'd0, overflow}, 32'd0);

      // Overflow: accept mid-drain is dropped, frame intact, next frame from 0.
      send_frame(40, 0);
      drain(40, NSAMP, 1'b0, 5, 8'h77, 1'b0, 8'h00);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      send_frame(60, 0);
      drain(60, NSAMP, 1'b0, -1, 8'h00, 1'b0, 8'h00);
      chk("ovf_sticky2", {31'd0, overflow}, 32'd1);

      // Reset after 10 outputs, then a fresh frame.
      send_frame(48, 0);
      drain(48, 10, 1'b0, -1, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", {31'd0, fm_valid}, 32'd0);
      chk("mrst_ovf",   {31'd0, overflow}, 32'd0);
      chk("mrst_data",  {24'd0, fm_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(80, 0);
      drain(80, NSAMP, 1'b0, -1, 8'h00, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pool_fm_buffer.md
# pool_fm_buffer

Receiving end of the pooling output stream. Qualifies `pool_data` with `cnn_out && pool_flag`, de-interleaves the channel-interleaved samples (ch0, ch1, ch2 per pooled position), and stores one pooled frame in channel-major order. It then drains the frame to the next layer over a valid/ready stream, one channel plane at a time.

## Interface
Parameters:
- `POOL_ROWS`, 3: pooled rows per frame. Each row holds 3 pooled columns × 3 channels, so a frame is 9·POOL_ROWS samples.
- `DW`, 8: sample width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cnn_out` in 1: CNN core output strobe.
- `pool_flag` in 1: pooling-complete level. A sample is accepted only when `cnn_out && pool_flag`.
- `pool_data` in DW: pooled sample.
- `fm_valid` out 1: output sample valid.
- `fm_ready` in 1: downstream ready.
- `fm_data` out DW: output sample.
- `fm_ch` out 2: channel of the current output sample (0–2).
- `fm_last` out 1: asserted with the final sample of the frame.
- `overflow` out 1: sticky; a sample was dropped.

## Operation
- States: FILL and DRAIN. Reset enters FILL.
- Write counters:
  - `wch` (0–2) increments on every accept and wraps 2→0.
  - On the `wch` wrap, `wcol` (0–2) increments.
  - On the `wcol` wrap, `wrow` (0..POOL_ROWS-1) increments.
- Write address = `wch·NPIX + wrow·3 + wcol`, with NPIX = 3·POOL_ROWS.
- FILL:
  - Each accept writes `pool_data` at the write address.
  - The accept with `wch=2, wcol=2, wrow=POOL_ROWS-1` clears all write counters and moves the FSM to DRAIN.
- DRAIN:
  - Read pointer `rptr` runs 0..3·NPIX-1.
  - `fm_data = mem[rptr]`, `fm_ch = rptr / NPIX`, `fm_last = (rptr == 3·NPIX-1)`.
  - `rptr` advances on `fm_valid && fm_ready`.
  - The handshake with `fm_last` clears `rptr` and returns the FSM to FILL.
- An accept during DRAIN drops the sample and sets `overflow`. The write counters do not advance.
  - Exception: an accept in the same cycle as the final DRAIN handshake is written normally (address 0, already read) and counts as the first sample of the next frame.
- `overflow` clears only on reset.
- Arithmetic: counters are unsigned and sized by `$clog2` of their range. There is no saturation; every wrap is explicit at the terminal value.

## Timing
- Reset values: `fm_valid`=0, `fm_data`=0, `fm_ch`=0, `fm_last`=0, `overflow`=0. All counters are 0 and the state is FILL.
- Write is registered. Data written on cycle N is readable from cycle N+1.
- `fm_valid` rises the cycle after the final FILL accept (latency 1) and stays high throughout DRAIN.
- `fm_data`, `fm_ch` and `fm_last` are stable while `fm_valid && !fm_ready`.
- Throughput in DRAIN is one sample per cycle with `fm_ready` held high. Frame drain takes 9·POOL_ROWS cycles.
- `fm_valid` falls the cycle after the `fm_last` handshake.
- `fm_ready` is ignored in FILL. `cnn_out` without `pool_flag` has no effect in either state.
- Asynchronous reset mid-FILL or mid-DRAIN discards the partial frame. The block restarts in FILL at counter 0.

## Structure
- Shared package `lenet_pkg` holds:
  - `POOL_NCH` = 3 and `POOL_NCOL` = 3.
  - The sample width default of 8.
  - The `fm_state_t` enum (FILL, DRAIN).
- Sub-module `pool_fm_ram`: a register-array memory with 1 write port and 1 combinational read port, depth 9·POOL_ROWS, width DW, asynchronous active-low reset to zero.
- Top level contains the FSM, the write and read counters, and address generation.

## Test plan
- POOL_ROWS=3: send 27 accepts with `pool_data` = 0..26 in order, `fm_ready`=1.
  - Required `fm_data` sequence: 0,3,6,9,…,24, then 1,4,…,25, then 2,5,…,26.
  - `fm_ch` = 0×9, 1×9, 2×9; `fm_last` only on 26; `fm_valid` rises 1 cycle after the 27th accept.
- Backpressure: toggle `fm_ready` every other cycle during DRAIN.
  - Data and channel stay held while stalled; the same 27-sample order results; no loss or duplication.
- Qualification: interleave `cnn_out`=1 with `pool_flag`=0, and `pool_flag`=1 with `cnn_out`=0.
  - No writes occur, and counters are unchanged.
- Overflow: issue an accept mid-DRAIN.
  - `overflow`=1 the next cycle and stays set.
  - The drained frame is unchanged, and the next frame starts at address 0.
- Simultaneous event: accept value 0xAA in the same cycle as the `fm_last` handshake.
  - Next frame's first output is 0xAA at ch0 index 0; `overflow` stays 0.
- Reset mid-DRAIN after 10 outputs: the block returns to FILL with `fm_valid`=0, and a fresh 27-sample frame drains correctly.
